mux_8_1_rr_sched: RTL and testbench
===================================

// Module: mux_8_1_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one mux_8_1 datapath between 8 requesters.
//  Drives the mux selects S0/S1/S2 from the winning requester and registers the
//  selected data bit with a valid strobe. Sits in front of mux_8_1: requesters
//  raise req[i], the block grants one at a time and steers D[i] to out.
// PARAMETERS
//  HOLD_MAX  4  max consecutive GRANT cycles per win (legal 1..255)
//  CNT_W     8  width of hold counter (must hold HOLD_MAX-1)
// PORTS
//  clk        in   1  single clock, all state on posedge
//  rst        in   1  asynchronous, active-high reset
//  req        in   8  request per requester, level, held until served
//  D          in   8  data bit per requester (D[i] <-> mux input Di)
//  S0,S1,S2   out  1  mux select, {S2,S1,S0} = index of current grant
//  grant      out  8  one-hot grant, all-zero when idle
//  busy       out  1  1 while in GRANT state
//  out        out  1  registered D[{S2,S1,S0}], one cycle after grant cycle
//  out_valid  out  1  qualifies out, one cycle after grant cycle
// BEHAVIOUR
//  Reset (async assert, sync to clk on release): state=IDLE, grant=0,
//   S2..S0=0, busy=0, out=0, out_valid=0, hold_cnt=0, last=7 (so req[0] wins first).
//  Arbitration: winner = first i with req[i]=1 searching last+1, last+2, ... mod 8.
//  IDLE: if |req at posedge -> GRANT, grant<=onehot(win), sel<=win, last<=win,
//   hold_cnt<=0. Latency req->grant = 1 clk. No req -> stay IDLE, outputs 0.
//  GRANT: each cycle out<=D[sel], out_valid<=1 (registered, appear next cycle).
//   hold_cnt++ each cycle. End of grant when req[sel]=0 OR hold_cnt==HOLD_MAX-1.
//   At end: if any other req (or req[sel] still 1 after expiry) -> re-arbitrate
//   from last, back-to-back next GRANT, hold_cnt<=0, no idle gap; else -> IDLE.
//  Expired requester still requesting competes normally; it is lowest RR priority,
//   so it is re-granted only if no other req is pending.
//  req[sel] dropping: grant ends that same edge; D[sel] for that cycle is still
//   captured only if req[sel] was 1 at the edge (out_valid tracks req&grant).
//  Selects held stable for whole grant; change only at grant boundaries.
//  Reset mid-grant: all outputs 0 immediately, pending out_valid discarded.
//  HOLD_MAX=1: every grant lasts exactly 1 cycle, pure RR rotation.
// CONFIGURATION
//  MUX_8_1_SCHED_PRIO_EN defined: requester 0 is strict priority; at any
//   arbitration point req[0]=1 wins; RR applies among 1..7 only; `last` tracks
//   only 1..7 winners. Requester 0 still limited by HOLD_MAX.
//  Not defined: pure round-robin across all 8, as above.
// TESTING
//  Compare out against a golden mux_8_1 fed the same D and S2..S0; count mismatches.
//  1 reset then req=8'h00 for 10 clk -> grant=0, busy=0, out_valid=0 throughout.
//  2 D=8'b01010101, req=8'hFF, HOLD_MAX=1 -> grant 0,1,..,7,0 each one cycle;
//   {S2,S1,S0}=0..7; out sequence 1,0,1,0,1,0,1,0 one cycle late.
//  3 req=8'h04 held, HOLD_MAX=4 -> grant 8'h04 continuous, sel=2, no gap at expiry.
//  4 req=8'h81, HOLD_MAX=4 -> grant[0] 4 clk, grant[7] 4 clk, alternating.
//  5 req[3]=1 drops after 2 grant cycles with req[5]=1 -> grant[5] next edge, out_valid 2 for req3.
//  6 rst pulse mid-grant of req[6] -> outputs 0 async; after release req=8'hFF -> grant[0] first.
//  With MUX_8_1_SCHED_PRIO_EN: req=8'h03, HOLD_MAX=2 -> grant 0 repeatedly, 1 starved.

Source files
------------

// File: rtl/mux_8_1_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux between 8 requesters; registers the selected bit with a valid strobe.
// Optional MUX_8_1_SCHED_PRIO_EN: requester 0 becomes strict priority, round-robin among 1..7 only.
module mux_8_1_rr_sched #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] D,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic [7:0] grant,
    output logic       busy,
    output logic       out,
    output logic       out_valid
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e           state_q;
    logic [7:0]       grant_q;
    logic [2:0]       sel_q;
    logic [2:0]       last_q;
    logic             busy_q;
    logic             out_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;

    logic [7:0]       rr_req_c;
    logic [2:0]       idx_c;
    logic [2:0]       win_c;
    logic             found_c;
    logic             end_c;

    // Winner search starts just after the last winner, so the last winner ranks lowest.
    always_comb begin
        rr_req_c = req;
        idx_c    = 3'd0;
        win_c    = 3'd0;
        found_c  = 1'b0;
`ifdef MUX_8_1_SCHED_PRIO_EN
        rr_req_c[0] = 1'b0;
`endif
        for (int unsigned k = 1; k <= 8; k++) begin
            idx_c = last_q + 3'(k);
            if (!found_c && rr_req_c[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
`ifdef MUX_8_1_SCHED_PRIO_EN
        if (req[0]) begin
            found_c = 1'b1;
            win_c   = 3'd0;
        end
`endif
    end

    assign hold_cnt_d = hold_cnt_q + CNT_W'(1);
    assign end_c      = !req[sel_q] || (hold_cnt_q == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 8'd0;
            sel_q       <= 3'd0;
            last_q      <= 3'd7;
            busy_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            // A grant cycle delivers data only while its requester is still asking.
            if (state_q == GRANT && req[sel_q]) begin
                out_q       <= D[sel_q];
                out_valid_q <= 1'b1;
            end
            if (state_q == IDLE || end_c) begin
                if (found_c) begin
                    state_q    <= GRANT;
                    grant_q    <= 8'(1) << win_c;
                    sel_q      <= win_c;
                    busy_q     <= 1'b1;
                    hold_cnt_q <= '0;
`ifdef MUX_8_1_SCHED_PRIO_EN
                    if (win_c != 3'd0) begin
                        last_q <= win_c;
                    end
`else
                    last_q     <= win_c;
`endif
                end else begin
                    state_q    <= IDLE;
                    grant_q    <= 8'd0;
                    sel_q      <= 3'd0;
                    busy_q     <= 1'b0;
                    hold_cnt_q <= '0;
                end
            end else begin
                hold_cnt_q <= hold_cnt_d;
            end
        end
    end

    assign S0        = sel_q[0];
    assign S1        = sel_q[1];
    assign S2        = sel_q[2];
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_8_1_rr_sched.sv
// Bench for mux_8_1_rr_sched: a HOLD_MAX=4 and a HOLD_MAX=1 instance share stimulus; outputs scored against a golden 8:1 mux.
module tb_mux_8_1_rr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] D   = 8'h00;

    logic       s0_a, s1_a, s2_a, busy_a, out_a, ov_a;
    logic [7:0] grant_a;
    logic       s0_b, s1_b, s2_b, busy_b, out_b, ov_b;
    logic [7:0] grant_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic       q_a[$];
    logic       q_b[$];
    logic [7:0] exp_g[$];
    logic       exp_o[$];

    always #5 clk = ~clk;

    mux_8_1_rr_sched #(.HOLD_MAX(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .D(D),
        .S0(s0_a), .S1(s1_a), .S2(s2_a), .grant(grant_a),
        .busy(busy_a), .out(out_a), .out_valid(ov_a)
    );

    mux_8_1_rr_sched #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .D(D),
        .S0(s0_b), .S1(s1_b), .S2(s2_b), .grant(grant_b),
        .busy(busy_b), .out(out_b), .out_valid(ov_b)
    );

    function automatic logic golden_mux(input logic [7:0] d, input logic s2, input logic s1, input logic s0);
        case ({s2, s1, s0})
            3'd0:    return d[0];
            3'd1:    return d[1];
            3'd2:    return d[2];
            3'd3:    return d[3];
            3'd4:    return d[4];
            3'd5:    return d[5];
            3'd6:    return d[6];
            default: return d[7];
        endcase
    endfunction

    // Scoreboard: push the golden mux bit on each served grant cycle, pop when out_valid shows up.
    always @(posedge clk) begin : mon_a
        logic e;
        if (rst) begin
            q_a.delete();
        end else begin
            if (ov_a) begin
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_a_spurious_valid out=%b with no pending grant cycle", out_a);
                end else begin
                    e = q_a.pop_front();
                    if (out_a !== e) begin
                        n_fail++;
                        $display("FAIL mon_a_out got %b expected %b", out_a, e);
                    end
                end
            end else if (q_a.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_a_missing_valid got out_valid=0 expected 1");
                q_a.delete();
            end
            if ((req & grant_a) != 8'h00) q_a.push_back(golden_mux(D, s2_a, s1_a, s0_a));
        end
    end

    always @(posedge clk) begin : mon_b
        logic e;
        if (rst) begin
            q_b.delete();
        end else begin
            if (ov_b) begin
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_b_spurious_valid out=%b with no pending grant cycle", out_b);
                end else begin
                    e = q_b.pop_front();
                    if (out_b !== e) begin
                        n_fail++;
                        $display("FAIL mon_b_out got %b expected %b", out_b, e);
                    end
                end
            end else if (q_b.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_b_missing_valid got out_valid=0 expected 1");
                q_b.delete();
            end
            if ((req & grant_b) != 8'h00) q_b.push_back(golden_mux(D, s2_b, s1_b, s0_b));
        end
    end

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({grant_a, busy_a, ov_a, out_a, s2_a, s1_a, s0_a} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_a got grant=%h busy=%b ov=%b out=%b sel=%0d expected all 0",
                     grant_a, busy_a, ov_a, out_a, {s2_a, s1_a, s0_a});
        end
        n_checks++;
        if ({grant_b, busy_b, ov_b, out_b, s2_b, s1_b, s0_b} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_b got grant=%h busy=%b ov=%b expected all 0", grant_b, busy_b, ov_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            D = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if ({grant_a, busy_a, ov_a} !== 10'd0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d got grant=%h busy=%b ov=%b expected 00/0/0", i, grant_a, busy_a, ov_a);
            end
        end
    endtask

    task automatic test_rr_hold1();
        logic [7:0] dv;
        logic [7:0] eg;
        logic       eo;
        dv = 8'b01010101;
        do_reset();
        D   = dv;
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_g.push_back(8'(1) << (i % 8));
            if (i > 0) exp_o.push_back(dv[(i - 1) % 8]);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            eg = exp_g.pop_front();
            n_checks++;
            if (grant_b !== eg || {s2_b, s1_b, s0_b} !== 3'(i % 8)) begin
                n_fail++;
                $display("FAIL rr1_grant%0d got grant=%h sel=%0d expected grant=%h sel=%0d",
                         i, grant_b, {s2_b, s1_b, s0_b}, eg, i % 8);
            end
            if (i > 0) begin
                eo = exp_o.pop_front();
                n_checks++;
                if (out_b !== eo || ov_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr1_out%0d got out=%b ov=%b expected out=%b ov=1", i, out_b, ov_b, eo);
                end
            end
        end
        drain();
    endtask

    task automatic test_hold();
        logic [7:0] eg;
        do_reset();
        req = 8'h04;
        repeat (12) exp_g.push_back(8'h04);
        for (int i = 0; i < 12; i++) begin
            D = 8'($urandom);
            @(negedge clk);
            eg = exp_g.pop_front();
            n_checks++;
            if (grant_a !== eg || {s2_a, s1_a, s0_a} !== 3'd2 || busy_a !== 1'b1 || (i > 0 && ov_a !== 1'b1)) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got grant=%h sel=%0d busy=%b ov=%b expected grant=%h sel=2 busy=1 ov=%b",
                         i, grant_a, {s2_a, s1_a, s0_a}, busy_a, ov_a, eg, i > 0);
            end
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if ({grant_a, busy_a, ov_a} !== 10'd0) begin
            n_fail++;
            $display("FAIL hold_release got grant=%h busy=%b ov=%b expected 00/0/0", grant_a, busy_a, ov_a);
        end
        drain();
    endtask

    task automatic test_alternate();
        logic [7:0] eg;
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 16; i++) exp_g.push_back(((i / 4) % 2 == 1) ? 8'h80 : 8'h01);
        for (int i = 0; i < 16; i++) begin
            D = 8'($urandom);
            @(negedge clk);
            eg = exp_g.pop_front();
            n_checks++;
            if (grant_a !== eg) begin
                n_fail++;
                $display("FAIL alt_cycle%0d got grant=%h expected %h", i, grant_a, eg);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int nv;
        nv = 0;
        do_reset();
        req = 8'h28;
        for (int i = 0; i < 3; i++) begin
            D = 8'($urandom);
            @(negedge clk);
            if (ov_a) nv++;
            n_checks++;
            if (grant_a !== 8'h08 || {s2_a, s1_a, s0_a} !== 3'd3) begin
                n_fail++;
                $display("FAIL b2b_req3_cycle%0d got grant=%h sel=%0d expected 08 sel=3", i, grant_a, {s2_a, s1_a, s0_a});
            end
        end
        req = 8'h20;
        @(negedge clk);
        if (ov_a) nv++;
        n_checks++;
        if (grant_a !== 8'h20 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_handover got grant=%h busy=%b expected 20 busy=1", grant_a, busy_a);
        end
        n_checks++;
        if (nv != 2) begin
            n_fail++;
            $display("FAIL b2b_req3_valid_count got %0d expected 2", nv);
        end
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h20 || ov_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_req5_serve got grant=%h ov=%b expected 20 ov=1", grant_a, ov_a);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h40;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h40 || ov_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got grant=%h ov=%b expected 40 ov=1", grant_a, ov_a);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({grant_a, busy_a, ov_a, out_a, s2_a, s1_a, s0_a} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrst_async got grant=%h busy=%b ov=%b out=%b sel=%0d expected all 0",
                     grant_a, busy_a, ov_a, out_a, {s2_a, s1_a, s0_a});
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h01 || grant_b !== 8'h01) begin
            n_fail++;
            $display("FAIL midrst_first_win got grant_a=%h grant_b=%h expected 01 01", grant_a, grant_b);
        end
        drain();
    endtask

`ifdef MUX_8_1_SCHED_PRIO_EN
    task automatic test_prio();
        do_reset();
        req = 8'h03;
        for (int i = 0; i < 10; i++) begin
            D = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (grant_a !== 8'h01 || grant_b !== 8'h01) begin
                n_fail++;
                $display("FAIL prio_cycle%0d got grant_a=%h grant_b=%h expected 01 01", i, grant_a, grant_b);
            end
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_rr_hold1();
        test_hold();
        test_alternate();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX_8_1_SCHED_PRIO_EN
        test_prio();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
